register_writeback: RTL
=======================

Name: register_writeback

Overview:
- Write-back end of the register-file interface; the Read stage is the consumer on the other side.
- Accepts completed results from execute and commits them into the architectural 16x64 register file.
- Drives the register-file array, per-register busy scoreboard and wbStall back to Read.
- Sequences two-destination instructions (IMUL RDX:RAX) over two cycles using a single physical write port.

Parameters:
- NUM_REGS, 16, number of architectural GPRs; register code width fixed at 4 bits.
- DATA_W, 64, register width.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous active-low reset.
- wbValidIn  in  1  execute presents a completed instruction this cycle.
- destRegIn  in  [0:3]  primary destination register code.
- destRegValidIn  in  1  primary destination present.
- resultIn  in  [63:0]  primary result value.
- destRegisterSpecialIn  in  [0:3]  secondary destination (e.g. RDX for IMUL).
- destRegisterSpecialValidIn  in  1  secondary destination present.
- resultSpecialIn  in  [63:0]  secondary result value.
- issueValidIn  in  1  Read stage read succeeded this cycle (its isReadSuccessful).
- issueDestRegIn  in  [0:3]  destination of the issuing instruction.
- issueDestRegValidIn  in  1  issuing destination valid.
- issueDestSpecialIn  in  [0:3]  issuing secondary destination.
- issueDestSpecialValidIn  in  1  issuing secondary destination valid.
- registerFileOut  out  [63:0] x16  architectural register array to Read.
- regBusyOut  out  [15:0]  scoreboard; bit n=1 while register n has a pending producer.
- wbStallOut  out  1  write-back occupied; Read and execute must hold.
- wbDoneOut  out  1  one-cycle pulse when an instruction fully retires.
- retiredCountOut  out  [CNT_W-1:0]  retired-instruction count.

Behaviour:
- Reset (resetN=0, async): all registers 0; regBusyOut=0; state IDLE; wbStallOut=0; wbDoneOut=0; retiredCountOut=0.
- Reset mid-SPECIAL abandons the pending write. Return to IDLE; nothing is written.
- FSM states: IDLE, SPECIAL.
- IDLE, wbValidIn=1, primary valid, secondary invalid:
  - Write resultIn to destRegIn at the edge; clear its busy bit.
  - Pulse wbDoneOut next cycle; retiredCountOut+1.
- IDLE, secondary valid, primary invalid:
  - Write resultSpecialIn in one cycle; same completion as above.
- IDLE, both valid:
  - Write primary at edge 1; latch secondary code and value.
  - Go to SPECIAL; wbStallOut=1 (registered) during SPECIAL.
- SPECIAL:
  - Write the latched secondary; clear its busy bit.
  - wbDoneOut and count+1 at this edge; return to IDLE; wbStallOut=0.
  - wbValidIn is ignored in SPECIAL; upstream holds while stalled.
- IDLE, wbValidIn=1, neither destination valid (e.g. CMP, JMP): no write; wbDoneOut pulse; count+1.
- Primary and secondary codes equal: the secondary value is the final value.
- Scoreboard:
  - issueValidIn sets busy for each valid issue destination.
  - Set and clear of the same register in the same cycle: set wins (newer producer).
- Counter wraps modulo 2^CNT_W.
- Write latency: value visible on registerFileOut the cycle after the write edge.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - registerFileOut combinationally forwards the value being written this cycle, so Read sees it with zero added latency.
  - regBusyOut for that register reads 0 in that cycle, unless the set-wins rule applies.
- Undefined: registerFileOut and regBusyOut are the pure registered state.

Decomposition:
- Shared package (wb_pkg):
  - constants NUM_REGS and REG_CODE_W=4;
  - FSM enum wb_state_t {IDLE, SPECIAL};
  - register index constants (RAX=0, RDX=2, RSP=4).
- One natural sub-module: wb_scoreboard (busy bits with set/clear priority).
- Register array and FSM stay in the top.

Test Plan:
- Reset: write R3=0xDEAD then assert resetN=0 -> registerFileOut[3]=0, regBusyOut=0, retiredCountOut=0 immediately.
- Single write: wbValidIn, destReg=5, result=0x1234 -> registerFileOut[5]=0x1234 next cycle, wbDoneOut one pulse, count=1, wbStallOut stays 0.
- IMUL: dest=0 result=0x11, special=2 resultSpecial=0x22 -> R0=0x11 after edge 1; wbStallOut=1 for one cycle; R2=0x22 after edge 2; single wbDoneOut; count+1.
- Same-code dual write: dest=7 val=0xA, special=7 val=0xB -> R7 ends 0xB.
- Scoreboard: issue dest=4 -> busy[4]=1; same cycle as a write-back to 4, issue dest=4 again -> busy[4] stays 1; next write-back to 4 -> busy[4]=0.
- Stall ignore, and WB_BYPASS_EN:
  - wbValidIn with dest=9 during SPECIAL -> R9 unchanged.
  - With WB_BYPASS_EN, write R1=0x55 -> registerFileOut[1]=0x55 in the same cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants, FSM state type and helpers for the register write-back slice.
package wb_pkg;

   localparam int unsigned NUM_REGS   = 16;
   localparam int unsigned REG_CODE_W = 4;

   typedef logic [0:REG_CODE_W-1] reg_code_t;

   typedef enum logic {
      IDLE    = 1'b0,
      SPECIAL = 1'b1
   } wb_state_t;

   localparam reg_code_t RAX = 4'd0;
   localparam reg_code_t RDX = 4'd2;
   localparam reg_code_t RSP = 4'd4;

   function automatic logic [NUM_REGS-1:0] regOneHot(input reg_code_t code, input logic en);
      regOneHot = '0;
      if (en) regOneHot[code] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Execute/Read-side signal bundle of the write-back stage; slave is the write-back end.
interface wb_if #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned CNT_W    = 64
);
   import wb_pkg::*;

   logic                             wbValidIn;
   reg_code_t                        destRegIn;
   logic                             destRegValidIn;
   logic [DATA_W-1:0]                resultIn;
   reg_code_t                        destRegisterSpecialIn;
   logic                             destRegisterSpecialValidIn;
   logic [DATA_W-1:0]                resultSpecialIn;

   logic                             issueValidIn;
   reg_code_t                        issueDestRegIn;
   logic                             issueDestRegValidIn;
   reg_code_t                        issueDestSpecialIn;
   logic                             issueDestSpecialValidIn;

   logic [NUM_REGS-1:0][DATA_W-1:0]  registerFileOut;
   logic [NUM_REGS-1:0]              regBusyOut;
   logic                             wbStallOut;
   logic                             wbDoneOut;
   logic [CNT_W-1:0]                 retiredCountOut;

   modport slave (
      input  wbValidIn, destRegIn, destRegValidIn, resultIn,
             destRegisterSpecialIn, destRegisterSpecialValidIn, resultSpecialIn,
             issueValidIn, issueDestRegIn, issueDestRegValidIn,
             issueDestSpecialIn, issueDestSpecialValidIn,
      output registerFileOut, regBusyOut, wbStallOut, wbDoneOut, retiredCountOut
   );

   modport master (
      output wbValidIn, destRegIn, destRegValidIn, resultIn,
             destRegisterSpecialIn, destRegisterSpecialValidIn, resultSpecialIn,
             issueValidIn, issueDestRegIn, issueDestRegValidIn,
             issueDestSpecialIn, issueDestSpecialValidIn,
      input  registerFileOut, regBusyOut, wbStallOut, wbDoneOut, retiredCountOut
   );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, a same-cycle set beats the clear.
// With WB_BYPASS_EN the bit being cleared this cycle already reads 0 (unless re-set).
module wb_scoreboard #(
   parameter int unsigned NUM_REGS = 16
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [NUM_REGS-1:0] setVec,
   input  logic [NUM_REGS-1:0] clrVec,
   output logic [NUM_REGS-1:0] busyOut
);

   logic [NUM_REGS-1:0] busyQ;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) busyQ <= '0;
      else         busyQ <= (busyQ & ~clrVec) | setVec;
   end

   always_comb begin
`ifdef WB_BYPASS_EN
      busyOut = busyQ & ~(clrVec & ~setVec);
`else
      busyOut = busyQ;
`endif
   end

endmodule

// File: rtl/register_writeback.sv
// Write-back stage: commits execute results into the 16x64 GPR file over one write port.
// Define WB_BYPASS_EN to forward the in-flight write onto registerFileOut/regBusyOut.
module register_writeback #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned CNT_W    = 64
) (
   input  logic clk,
   input  logic resetN,
   wb_if.slave  bus
);
   import wb_pkg::*;

   wb_state_t                        state, stateNext;
   logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
   reg_code_t                        pendCode;
   logic [DATA_W-1:0]                pendData;
   logic                             latchPend;
   logic                             wrEn;
   reg_code_t                        wrIdx;
   logic [DATA_W-1:0]                wrData;
   logic                             retire;
   logic                             wbDoneQ;
   logic [CNT_W-1:0]                 retiredQ;
   logic [NUM_REGS-1:0]              setVec, clrVec;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= stateNext;
   end

   // Single write port: a dual-destination instruction writes primary now, latched secondary next cycle.
   always_comb begin
      stateNext = state;
      latchPend = 1'b0;
      wrEn      = 1'b0;
      wrIdx     = bus.destRegIn;
      wrData    = bus.resultIn;
      retire    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.wbValidIn) begin
               if (bus.destRegValidIn && bus.destRegisterSpecialValidIn) begin
                  wrEn      = 1'b1;
                  latchPend = 1'b1;
                  stateNext = SPECIAL;
               end else if (bus.destRegValidIn) begin
                  wrEn   = 1'b1;
                  retire = 1'b1;
               end else if (bus.destRegisterSpecialValidIn) begin
                  wrEn   = 1'b1;
                  wrIdx  = bus.destRegisterSpecialIn;
                  wrData = bus.resultSpecialIn;
                  retire = 1'b1;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         SPECIAL: begin
            wrEn      = 1'b1;
            wrIdx     = pendCode;
            wrData    = pendData;
            retire    = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         regs     <= '0;
         pendCode <= '0;
         pendData <= '0;
         wbDoneQ  <= 1'b0;
         retiredQ <= '0;
      end else begin
         if (wrEn) regs[wrIdx] <= wrData;
         if (latchPend) begin
            pendCode <= bus.destRegisterSpecialIn;
            pendData <= bus.resultSpecialIn;
         end
         wbDoneQ <= retire;
         if (retire) retiredQ <= retiredQ + CNT_W'(1);
      end
   end

   always_comb begin
      clrVec = regOneHot(wrIdx, wrEn);
      setVec = regOneHot(bus.issueDestRegIn, bus.issueValidIn && bus.issueDestRegValidIn)
             | regOneHot(bus.issueDestSpecialIn, bus.issueValidIn && bus.issueDestSpecialValidIn);
   end

   wb_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) scoreboard (
      .clk     (clk),
      .resetN  (resetN),
      .setVec  (setVec),
      .clrVec  (clrVec),
      .busyOut (bus.regBusyOut)
   );

   always_comb begin
      bus.registerFileOut = regs;
`ifdef WB_BYPASS_EN
      if (wrEn) bus.registerFileOut[wrIdx] = wrData;
`endif
   end

   always_comb begin
      bus.wbStallOut      = (state == SPECIAL);
      bus.wbDoneOut       = wbDoneQ;
      bus.retiredCountOut = retiredQ;
   end

endmodule
